// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory, with a
// bounded bus lock and registered read/error responses one cycle after grant.
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 8,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req_i,
   input  logic                  p0_we_i,
   input  logic                  p0_lock_i,
   input  logic [DATA_WIDTH-1:0] p0_addr_i,
   input  logic [DATA_WIDTH-1:0] p0_wdata_i,
   output logic                  p0_gnt_o,
   output logic                  p0_rvalid_o,
   output logic [DATA_WIDTH-1:0] p0_rdata_o,
   output logic                  p0_err_o,
   input  logic                  p1_req_i,
   input  logic                  p1_we_i,
   input  logic                  p1_lock_i,
   input  logic [DATA_WIDTH-1:0] p1_addr_i,
   input  logic [DATA_WIDTH-1:0] p1_wdata_i,
   output logic                  p1_gnt_o,
   output logic                  p1_rvalid_o,
   output logic [DATA_WIDTH-1:0] p1_rdata_o,
   output logic                  p1_err_o,
   output logic                  mem_write_o,
   output logic                  mem_read_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_P0   = 2'd1,
      LOCK_P1   = 2'd2
   } lock_state_e;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

   lock_state_e           lock_state_q, lock_state_d;
   logic                  last_grant_q, last_grant_d;
   logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
   logic                  p0_rvalid_q, p0_rvalid_d, p0_err_q, p0_err_d;
   logic                  p1_rvalid_q, p1_rvalid_d, p1_err_q, p1_err_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

   logic                  req0, req1, lock_active, lock_owner, owner_req, other_req;
   logic                  gnt_any, gnt_sel, gnt0, gnt1;
   logic                  sel_we, sel_lock, sel_other_req, misaligned;
   logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;

   always_comb begin
      // Requests are masked during reset so nothing is granted or written.
      req0        = p0_req_i & ~reset;
      req1        = p1_req_i & ~reset;
      lock_active = (lock_state_q != LOCK_NONE);
      lock_owner  = (lock_state_q == LOCK_P1);
      owner_req   = lock_owner ? req1 : req0;
      other_req   = lock_owner ? req0 : req1;
      gnt_any     = 1'b0;
      gnt_sel     = 1'b0;
      if (lock_active && owner_req && (!other_req || lock_cnt_q < MAX_CNT)) begin
         gnt_any = 1'b1;
         gnt_sel = lock_owner;
      end else if (lock_active && owner_req) begin
         gnt_any = 1'b1;
         gnt_sel = ~lock_owner;
      end else if (req0 && req1) begin
         gnt_any = 1'b1;
         gnt_sel = ~last_grant_q;
      end else if (req0 || req1) begin
         gnt_any = 1'b1;
         gnt_sel = req1;
      end
      gnt0          = gnt_any & ~gnt_sel;
      gnt1          = gnt_any & gnt_sel;
      sel_we        = gnt_sel ? p1_we_i    : p0_we_i;
      sel_lock      = gnt_sel ? p1_lock_i  : p0_lock_i;
      sel_addr      = gnt_sel ? p1_addr_i  : p0_addr_i;
      sel_wdata     = gnt_sel ? p1_wdata_i : p0_wdata_i;
      sel_other_req = gnt_sel ? req0 : req1;
      misaligned    = |sel_addr[1:0];
   end

   assign p0_gnt_o    = gnt0;
   assign p1_gnt_o    = gnt1;
   assign mem_write_o = gnt_any & ~misaligned & sel_we;
   assign mem_read_o  = gnt_any & ~misaligned & ~sel_we;
   assign mem_addr_o  = gnt_any ? sel_addr  : '0;
   assign mem_wdata_o = gnt_any ? sel_wdata : '0;

   always_comb begin
      last_grant_d = gnt_any ? gnt_sel : last_grant_q;
      lock_state_d = LOCK_NONE;
      lock_cnt_d   = '0;
      if (gnt_any && sel_lock) begin
         lock_state_d = gnt_sel ? LOCK_P1 : LOCK_P0;
         // The acquiring grant counts toward the bound when the other port waits.
         if (lock_active && (lock_owner == gnt_sel)) begin
            lock_cnt_d = lock_cnt_q;
            if (sel_other_req && lock_cnt_q < MAX_CNT)
               lock_cnt_d = lock_cnt_q + CNT_W'(1);
         end else begin
            lock_cnt_d = sel_other_req ? CNT_W'(1) : '0;
         end
      end

      p0_rvalid_d = gnt0 & (misaligned | ~sel_we);
      p0_err_d    = gnt0 & misaligned;
      p0_rdata_d  = p0_rdata_q;
      if (gnt0 && misaligned)   p0_rdata_d = '0;
      else if (gnt0 && !sel_we) p0_rdata_d = mem_rdata_i;

      p1_rvalid_d = gnt1 & (misaligned | ~sel_we);
      p1_err_d    = gnt1 & misaligned;
      p1_rdata_d  = p1_rdata_q;
      if (gnt1 && misaligned)   p1_rdata_d = '0;
      else if (gnt1 && !sel_we) p1_rdata_d = mem_rdata_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_state_q <= LOCK_NONE;
         last_grant_q <= 1'b1;
         lock_cnt_q   <= '0;
         p0_rvalid_q  <= 1'b0;
         p0_err_q     <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rvalid_q  <= 1'b0;
         p1_err_q     <= 1'b0;
         p1_rdata_q   <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         last_grant_q <= last_grant_d;
         lock_cnt_q   <= lock_cnt_d;
         p0_rvalid_q  <= p0_rvalid_d;
         p0_err_q     <= p0_err_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rvalid_q  <= p1_rvalid_d;
         p1_err_q     <= p1_err_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   assign p0_rvalid_o = p0_rvalid_q;
   assign p0_err_o    = p0_err_q;
   assign p0_rdata_o  = p0_rdata_q;
   assign p1_rvalid_o = p1_rvalid_q;
   assign p1_err_o    = p1_err_q;
   assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table followed by random traffic
// checked against a behavioural arbitration model and a word memory.
module tb_dmem_arbiter;

   localparam int MAX_LOCK = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_write, mem_read;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem_arr [64];
   assign mem_rdata = mem_arr[mem_addr[7:2]];

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_WIDTH(32), .MAX_LOCK(MAX_LOCK), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_lock_i(p0_lock),
      .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
      .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata), .p0_err_o(p0_err),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_lock_i(p1_lock),
      .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
      .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata), .p1_err_o(p1_err),
      .mem_write_o(mem_write), .mem_read_o(mem_read),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   typedef struct {
      logic        r0, w0, l0; logic [31:0] a0, d0;
      logic        r1, w1, l1; logic [31:0] a1, d1;
      logic        rst;
      logic        g0, g1, mw, mr; logic [31:0] ma, md;
      logic        rv0, er0; logic [31:0] rd0;
      logic        rv1, er1; logic [31:0] rd1;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk_b(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic r0, w0, l0, input logic [31:0] a0, d0,
      input logic r1, w1, l1, input logic [31:0] a1, d1,
      input logic rst,
      input logic g0, g1, mw, mr, input logic [31:0] ma, md,
      input logic rv0, er0, input logic [31:0] rd0,
      input logic rv1, er1, input logic [31:0] rd1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
      v.rst = rst;
      v.g0 = g0; v.g1 = g1; v.mw = mw; v.mr = mr; v.ma = ma; v.md = md;
      v.rv0 = rv0; v.er0 = er0; v.rd0 = rd0;
      v.rv1 = rv1; v.er1 = er1; v.rd1 = rd1;
      return v;
   endfunction

   // Apply one cycle: combinational checks before the edge, registered after.
   task automatic run(input vec_t v);
      p0_req = v.r0; p0_we = v.w0; p0_lock = v.l0; p0_addr = v.a0; p0_wdata = v.d0;
      p1_req = v.r1; p1_we = v.w1; p1_lock = v.l1; p1_addr = v.a1; p1_wdata = v.d1;
      reset  = v.rst;
      #2;
      chk_b("p0_gnt", p0_gnt, v.g0);
      chk_b("p1_gnt", p1_gnt, v.g1);
      chk_b("mem_write", mem_write, v.mw);
      chk_b("mem_read", mem_read, v.mr);
      chk_w("mem_addr", mem_addr, v.ma);
      chk_w("mem_wdata", mem_wdata, v.md);
      @(posedge clk);
      #1;
      if (v.mw) mem_arr[v.ma[7:2]] = v.md;
      cyc++;
      chk_b("p0_rvalid", p0_rvalid, v.rv0);
      chk_b("p0_err", p0_err, v.er0);
      chk_b("p1_rvalid", p1_rvalid, v.rv1);
      chk_b("p1_err", p1_err, v.er1);
      if (v.rv0) chk_w("p0_rdata", p0_rdata, v.rd0);
      if (v.rv1) chk_w("p1_rdata", p1_rdata, v.rd1);
   endtask

   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] M5 = 32'hA5A5_0005;
   localparam logic [31:0] WV = 32'h1234_5678;

   vec_t tbl[$];
   vec_t v;
   logic [1:0]  req, we, lk;
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic [31:0] rd_exp [2];
   logic [1:0]  rv_exp, er_exp;
   logic        mis;
   int          g, last_m, own_m, cnt_m;

   initial begin
      for (int i = 0; i < 64; i++) mem_arr[i] = 32'hA5A5_0000 | 32'(i);
      mem_arr[4] = DB;
      reset = 1'b1;
      p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
      p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
      @(posedge clk);
      #1;

      // reset state, reads, contention, write/read-back, misaligned accesses
      tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       1, 0,0,0,0,0,0,               0,0,0,  0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    0,0,0,0,0,       1, 0,0,0,0,0,0,               0,0,0,  0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    0,0,0,0,0,       0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
      tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       0, 0,0,0,0,0,0,               0,0,0,  0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,0,'h14,0,    0, 0,1,0,1,'h14,0,            0,0,0,  1,0,M5));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,0,'h14,0,    0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,0,'h14,0,    0, 0,1,0,1,'h14,0,            0,0,0,  1,0,M5));
      tbl.push_back(mk(0,0,0,0,0,       1,1,0,'h20,WV,   0, 0,1,1,0,'h20,WV,           0,0,0,  0,0,0));
      tbl.push_back(mk(1,0,0,'h20,0,    0,0,0,0,0,       0, 1,0,0,1,'h20,0,            1,0,WV, 0,0,0));
      tbl.push_back(mk(1,1,0,'h22,'1,   0,0,0,0,0,       0, 1,0,0,0,'h22,32'hFFFF_FFFF, 1,1,0,  0,0,0));
      tbl.push_back(mk(1,0,0,'h20,0,    0,0,0,0,0,       0, 1,0,0,1,'h20,0,            1,0,WV, 0,0,0));
      tbl.push_back(mk(0,0,0,0,0,       1,0,0,'h21,0,    0, 0,1,0,0,'h21,0,            0,0,0,  1,1,0));
      tbl.push_back(mk(1,0,0,'h10,0,    0,0,0,0,0,       0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
      tbl.push_back(mk(1,0,0,'h14,0,    0,0,0,0,0,       0, 1,0,0,1,'h14,0,            1,0,M5, 0,0,0));
      // reset mid-read, then contention from reset: p0 wins first
      tbl.push_back(mk(1,0,0,'h10,0,    0,0,0,0,0,       0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,0,'h14,0,    1, 0,0,0,0,0,0,               0,0,0,  0,0,0));
      for (int k = 0; k < 2; k++) begin
         tbl.push_back(mk(1,0,0,'h10,0, 1,0,0,'h14,0,    0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
         tbl.push_back(mk(1,0,0,'h10,0, 1,0,0,'h14,0,    0, 0,1,0,1,'h14,0,            0,0,0,  1,0,M5));
      end
      // lock bound: p1 holds at most MAX_LOCK consecutive grants against p0
      tbl.push_back(mk(0,0,0,0,0,       0,0,0,0,0,       1, 0,0,0,0,0,0,               0,0,0,  0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,1,'h14,0,    0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
      for (int k = 0; k < MAX_LOCK; k++)
         tbl.push_back(mk(1,0,0,'h10,0, 1,0,1,'h14,0,    0, 0,1,0,1,'h14,0,            0,0,0,  1,0,M5));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,1,'h14,0,    0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,1,'h14,0,    0, 0,1,0,1,'h14,0,            0,0,0,  1,0,M5));
      tbl.push_back(mk(0,0,0,0,0,       1,0,0,'h14,0,    0, 0,1,0,1,'h14,0,            0,0,0,  1,0,M5));
      tbl.push_back(mk(1,0,0,'h10,0,    1,0,0,'h14,0,    0, 1,0,0,1,'h10,0,            1,0,DB, 0,0,0));

      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

      // random traffic against the behavioural model, starting from reset
      last_m = 1; own_m = -1; cnt_m = 0;
      for (int i = 0; i < 800; i++) begin
         for (int p = 0; p < 2; p++) begin
            req[p] = ($urandom_range(0, 9) < 7);
            we[p]  = $urandom_range(0, 1) == 1;
            lk[p]  = ($urandom_range(0, 9) < 4);
            ad[p]  = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 4) == 0) ad[p] = ad[p] | 32'($urandom_range(1, 3));
            wd[p]  = $urandom;
            rd_exp[p] = '0;
         end
         rv_exp = '0; er_exp = '0;
         v = mk(req[0], we[0], lk[0], ad[0], wd[0], req[1], we[1], lk[1], ad[1], wd[1],
                (i == 0) || ($urandom_range(0, 39) == 0),
                0,0,0,0,0,0, 0,0,0, 0,0,0);
         g = -1;
         if (v.rst) begin
            last_m = 1; own_m = -1; cnt_m = 0;
         end else begin
            if (own_m >= 0 && req[own_m] && (!req[1-own_m] || cnt_m < MAX_LOCK)) g = own_m;
            else if (req[0] && req[1]) g = 1 - last_m;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
            if (g >= 0) begin
               mis  = (ad[g] % 4) != 0;
               v.ma = ad[g];
               v.md = wd[g];
               v.mw = !mis && we[g];
               v.mr = !mis && !we[g];
               rv_exp[g] = mis || !we[g];
               er_exp[g] = mis;
               rd_exp[g] = (mis || we[g]) ? 32'h0 : mem_arr[ad[g] / 4];
               last_m = g;
               if (lk[g]) begin
                  if (own_m == g) begin
                     if (req[1-g] && cnt_m < MAX_LOCK) cnt_m = cnt_m + 1;
                  end else begin
                     own_m = g;
                     cnt_m = req[1-g] ? 1 : 0;
                  end
               end else begin
                  own_m = -1; cnt_m = 0;
               end
            end else begin
               own_m = -1; cnt_m = 0;
            end
         end
         v.g0 = (g == 0); v.g1 = (g == 1);
         v.rv0 = rv_exp[0]; v.er0 = er_exp[0]; v.rd0 = rd_exp[0];
         v.rv1 = rv_exp[1]; v.er1 = er_exp[1]; v.rd1 = rd_exp[1];
         run(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory.
- Port 0 is the core load/store stage; port 1 is a secondary master (loader/debug/DMA).
- Issues at most one memory access per cycle, selected round-robin, with optional bounded bus lock.
- Returns read data registered, one cycle after grant; rejects misaligned word accesses.

Parameters:
- DATA_WIDTH, 32, data and address width.
- MAX_LOCK, 8, max consecutive grants a locking port may hold while the other port is requesting.
- CNT_W, 4, lock counter width; must satisfy 2^CNT_W > MAX_LOCK.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- p0_req_i  input  1  port 0 access request; held until granted.
- p0_we_i  input  1  port 0 write (1) / read (0).
- p0_lock_i  input  1  port 0 requests to keep the grant on its next request.
- p0_addr_i  input  DATA_WIDTH  port 0 byte address.
- p0_wdata_i  input  DATA_WIDTH  port 0 write data.
- p0_gnt_o  output  1  port 0 granted this cycle (combinational).
- p0_rvalid_o  output  1  port 0 read data / error valid (registered).
- p0_rdata_o  output  DATA_WIDTH  port 0 read data (registered).
- p0_err_o  output  1  port 0 misaligned-access error, qualified by p0_rvalid_o.
- p1_* : identical set for port 1.
- mem_write_o  output  1  to memory write enable.
- mem_read_o  output  1  to memory read enable.
- mem_addr_o  output  DATA_WIDTH  to memory byte address.
- mem_wdata_o  output  DATA_WIDTH  to memory write data.
- mem_rdata_i  input  DATA_WIDTH  from memory, combinational read data.

Behaviour:
- Reset: all rvalid/err/rdata registers 0; last_grant=1 (port 0 wins first tie); lock_owner=none; lock_cnt=0. mem_* and gnt_o are 0 whenever no request is granted.
- Arbitration is combinational and evaluated each cycle:
  - Lock rule: if lock is active, the owner requests, and (the other port is idle or lock_cnt < MAX_LOCK), grant the owner.
  - Otherwise: if only one port requests, grant it; if both request, grant the port != last_grant.
- Granted cycle, aligned address (addr[1:0]==0):
  - mem_addr_o/mem_wdata_o = granted port's signals.
  - mem_write_o = we; mem_read_o = !we.
  - Write is committed by memory at this edge.
- Granted cycle, misaligned address: mem_write_o=mem_read_o=0 (no memory effect). Next cycle that port's rvalid_o=1, err_o=1, rdata_o=0. Applies to both reads and writes.
- Aligned read: at the grant edge, rdata register <= mem_rdata_i. rvalid_o=1 for exactly one cycle in the following cycle. Latency is grant+1.
- Aligned write: no rvalid pulse; gnt_o is the acknowledge.
- Pipelined requests: a port may request every cycle; back-to-back grants yield back-to-back rvalid pulses.
- last_grant updates to the granted port on every grant edge.
- Lock state:
  - Set to the granted port when its lock_i=1 at grant.
  - Cleared when the owner is granted with lock_i=0, or when the owner has no request for a cycle.
- lock_cnt:
  - Increments on each owner grant while the other port requests; saturates at MAX_LOCK.
  - Reset to 0 on lock clear or on an ownership change.
  - At MAX_LOCK with the other port pending: grant the other port, and clear the lock.
- Simultaneous events: the rvalid of a previous read and a new grant in the same cycle are independent; both occur.
- Reset asserted mid-transaction: a pending rvalid is squashed (0 next cycle), and no write is issued in the reset cycle (gnt_o=0 while reset=1).

Test Plan:
- Single read: p0 read addr 0x10, mem word 0xDEADBEEF -> p0_gnt_o=1 in cycle N; p0_rvalid_o=1, p0_rdata_o=0xDEADBEEF in N+1 only.
- Contention: both ports read every cycle from reset -> grants alternate p0,p1,p0,p1; each rvalid arrives on its own port one cycle after its grant.
- Write then read: p1 writes 0x12345678 to 0x20, then p0 reads 0x20 -> p0_rdata_o=0x12345678; no rvalid on p1 for the write.
- Misaligned access: p0 write to 0x22 -> mem_write_o=0, p0_rvalid_o=1, p0_err_o=1 next cycle, and memory at 0x20 is unchanged.
- Lock starvation bound: p1 locks with continuous requests while p0 requests continuously -> p1 receives exactly MAX_LOCK=8 consecutive grants, then p0 is granted.
- Reset mid-read: assert reset in the cycle after a grant -> p0_rvalid_o=0; after release, both ports requesting -> p0 granted first.
